// File: rtl/alu_execute_unit.sv
// rtl/alu_execute_unit.sv - EX-stage ALU with valid/ready handshake, serial or barrel shifter (BARREL_SHIFTER_EN)
module alu_execute_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1110;
  localparam logic [3:0] OP_SLTU = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_PASS = 4'b1111;

`ifdef BARREL_SHIFTER_EN
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;

  // Single-cycle ops; shift codes return op_a shifted by shamt in the barrel
  // build, and op_a unchanged in the serial build (only reached when shamt==0).
  function automatic logic [XLEN-1:0] alu_fn(input logic [3:0] ctrl,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    logic [SHW-1:0]  sh;
    res = '0;
    sh  = b[SHW-1:0];
    case (ctrl)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  res = a ^ b;
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      OP_PASS: res = b;
`ifdef BARREL_SHIFTER_EN
      OP_SLL:  res = a << sh;
      OP_SRL:  res = a >> sh;
      OP_SRA:  res = $unsigned($signed(a) >>> sh);
`else
      OP_SLL, OP_SRL, OP_SRA: res = (sh == '0) ? a : '0;
`endif
      default: res = '0;
    endcase
    return res;
  endfunction

`ifdef BARREL_SHIFTER_EN
  // Next-state and result: every op finishes in one cycle.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          result_d = alu_fn(alu_ctrl, op_a, op_b);
          state_d  = S_DONE;
        end
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end
`else
  logic [3:0]      ctrl_q, ctrl_d;
  logic [XLEN-1:0] shreg_q, shreg_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] shift_one;

  // One-bit step of the serial shifter for the latched shift kind.
  always_comb begin
    shift_one = shreg_q;
    case (ctrl_q)
      OP_SLL:  shift_one = {shreg_q[XLEN-2:0], 1'b0};
      OP_SRL:  shift_one = {1'b0, shreg_q[XLEN-1:1]};
      OP_SRA:  shift_one = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
      default: shift_one = shreg_q;
    endcase
  end

  // Next-state: nonzero shifts iterate in SHIFT, the rest go straight to DONE.
  // The result register is only written on completion so zero never sees
  // in-flight shifter contents.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ctrl_d   = ctrl_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          ctrl_d = alu_ctrl;
          if ((alu_ctrl == OP_SLL || alu_ctrl == OP_SRL || alu_ctrl == OP_SRA) &&
              (op_b[SHW-1:0] != '0)) begin
            shreg_d = op_a;
            cnt_d   = op_b[SHW-1:0];
            state_d = S_SHIFT;
          end else begin
            result_d = alu_fn(alu_ctrl, op_a, op_b);
            state_d  = S_DONE;
          end
        end
        S_SHIFT: begin
          shreg_d = shift_one;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == SHW'(1)) begin
            result_d = shift_one;
            state_d  = S_DONE;
          end
        end
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, result and shifter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      ctrl_q   <= '0;
      shreg_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ctrl_q   <= ctrl_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_execute_unit.sv
// tb/tb_alu_execute_unit.sv - directed self-checking bench for alu_execute_unit
module tb_alu_execute_unit;

  localparam logic [3:0] C_ADD = 4'b0000, C_SUB = 4'b1000, C_SLL = 4'b1010;
  localparam logic [3:0] C_SLT = 4'b1110, C_SLTU = 4'b0001, C_XOR = 4'b0010;
  localparam logic [3:0] C_SRL = 4'b0110, C_SRA = 4'b1001, C_OR = 4'b1100;
  localparam logic [3:0] C_AND = 4'b0100, C_PASS = 4'b1111, C_BAD = 4'b0111;

`ifdef BARREL_SHIFTER_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_execute_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, measure cycles from accept to out_valid, check the
  // result and flags, then retire it with a one-cycle out_ready.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  function automatic int slat(input int n);
    return BARREL ? 0 : n;
  endfunction

  initial begin
    int rose;
    #12;
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'd0, out_valid, busy, zero, in_ready}, 32'b0011);
    rst_n = 1'b1;
    step();

    run_op("add_ovf",  C_ADD,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0);
    run_op("sub_zero", C_SUB,  32'd5, 32'd5, 32'd0, 0);
    run_op("unlisted", C_BAD,  32'd3, 32'd4, 32'd0, 0);
    run_op("sra4",     C_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000, slat(4));
    run_op("slt",      C_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 0);
    run_op("sltu",     C_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    run_op("sll0",     C_SLL,  32'h0000_1234, 32'd0, 32'h0000_1234, 0);
    run_op("sll3",     C_SLL,  32'd1, 32'h0000_0023, 32'd8, slat(3));
    run_op("srl31",    C_SRL,  32'h8000_0000, 32'd31, 32'd1, slat(31));
    run_op("xor",      C_XOR,  32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 0);
    run_op("or",       C_OR,   32'hA000_0001, 32'h0500_0010, 32'hA500_0011, 0);
    run_op("and",      C_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 0);
    run_op("pass_b",   C_PASS, 32'h1111_1111, 32'hCAFE_BABE, 32'hCAFE_BABE, 0);

    // Backpressure: hold DONE for 3 cycles while in_valid pulses are offered.
    alu_ctrl = C_ADD; op_a = 32'd1; op_b = 32'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp_valid0", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      alu_ctrl = C_PASS; op_b = 32'hDEAD_0000 + i; in_valid = (i != 1);
      step();
      check("bp_result", result, 32'd3);
      check("bp_flags", {29'd0, out_valid, in_ready, busy}, 32'b101);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release", {29'd0, out_valid, in_ready, busy}, 32'b010);
    check("bp_hold", result, 32'd3);

    // flush wins over in_valid in IDLE.
    flush = 1'b1; in_valid = 1'b1; alu_ctrl = C_ADD; op_a = 32'd9; op_b = 32'd9;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle", {29'd0, out_valid, in_ready, busy}, 32'b010);

    // Flush 10 cycles into a 31-bit serial shift.
    alu_ctrl = C_SLL; op_a = 32'd1; op_b = 32'd31; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("fl_pre", {30'd0, out_valid, busy}, BARREL ? 32'b11 : 32'b01);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_post", {29'd0, out_valid, in_ready, busy}, 32'b010);
    check("fl_result", result, BARREL ? 32'h8000_0000 : 32'd3);
    rose = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) rose = 1;
    end
    check("fl_no_valid", rose, 0);

    // Async reset 10 cycles into the same shift.
    alu_ctrl = C_SLL; op_a = 32'd1; op_b = 32'd31; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_result", result, 32'd0);
    check("ar_flags", {28'd0, out_valid, busy, zero, in_ready}, 32'b0011);
    #3;
    rst_n = 1'b1;
    rose = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) rose = 1;
    end
    check("ar_no_valid", rose, 0);
    check("ar_end", {29'd0, in_ready, busy, zero}, 32'b101);

    run_op("post_add", C_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
